// File: rtl/axibram_pkg.sv
// Shared constants, FSM state type and a constant-safe clog2 helper for the
// AXI BRAM read slave.
package axibram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axibram_read_gen_if.sv
// AXI read-address and read-data channels bundled for the BRAM read slave.
interface axibram_read_gen_if #(
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 12,
  parameter int LEN_BITS  = 4
);
  logic [31:0]          araddr;
  logic                 arvalid;
  logic                 arready;
  logic [ID_BITS-1:0]   arid;
  logic [LEN_BITS-1:0]  arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rready;
  logic [ID_BITS-1:0]   rid;
  logic                 rlast;
  logic [1:0]           rresp;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  arready, rdata, rvalid, rid, rlast, rresp
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    output arready, rdata, rvalid, rid, rlast, rresp
  );
endinterface

// File: rtl/fifo_same_clock.sv
// Single-clock fall-through FIFO: dout shows the head entry whenever !empty.
// Any depth >= 2; writes when full and reads when empty are ignored.
module fifo_same_clock import axibram_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          empty,
  output logic                          full,
  output logic [clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_wr = we && !full;
  assign do_rd = re && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= inc(wp);
      if (do_rd) rp <= inc(rp);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end

endmodule

// File: rtl/axibram_read_gen.sv
// AXI read slave over BRAM: AR queue, FIXED/INCR/WRAP burst expansion, tag
// pipe matched to BRAM latency, credit-managed output FIFO. Optional macro
// AXIBRAM_READ_RANGE_CHECK_EN answers out-of-range bursts with SLVERR beats.
module axibram_read_gen import axibram_pkg::*; #(
  parameter int ADDRESS_BITS = 10,
  parameter int DATA_BITS    = 32,
  parameter int ID_BITS      = 12,
  parameter int LEN_BITS     = 4,
  parameter int BRAM_LAT     = 1,
  parameter int AR_DEPTH     = 4
) (
  input  logic                    aclk,
  input  logic                    rst,
  axibram_read_gen_if.slave       axi,
  output logic [ADDRESS_BITS-1:0] pre_araddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic                    bram_rclk,
  output logic [ADDRESS_BITS-1:0] bram_raddr,
  output logic                    bram_ren,
  output logic                    bram_regen,
  input  logic [DATA_BITS-1:0]    bram_rdata
);
  localparam int BL        = clog2(DATA_BITS / 8);
  localparam int STAGES    = BRAM_LAT - 1;
  localparam int OUT_DEPTH = BRAM_LAT + 2;

  typedef struct packed {
    logic                    oor;
    logic [ID_BITS-1:0]      id;
    logic [1:0]              burst;
    logic [LEN_BITS-1:0]     len;
    logic [ADDRESS_BITS-1:0] addr;
  } ar_req_t;

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic               last;
    logic [1:0]         resp;
  } tag_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    tag_t                 tag;
  } beat_t;

  // ---------------- AR queue ----------------
  ar_req_t ar_in, ar_head;
  logic    ar_empty, ar_full, ar_push, ar_pop, in_oor;
  logic [clog2(AR_DEPTH+1)-1:0] ar_count;

`ifdef AXIBRAM_READ_RANGE_CHECK_EN
  assign in_oor = |axi.araddr[31:ADDRESS_BITS+BL];
`else
  assign in_oor = 1'b0;
`endif

  assign ar_in = '{oor: in_oor, id: axi.arid, burst: axi.arburst, len: axi.arlen,
                   addr: axi.araddr[ADDRESS_BITS+BL-1:BL]};
  assign axi.arready = !ar_full;
  assign ar_push     = axi.arvalid && !ar_full;

  fifo_same_clock #(.WIDTH($bits(ar_req_t)), .DEPTH(AR_DEPTH)) u_ar_q (
    .clk(aclk), .rst(rst), .we(ar_push), .re(ar_pop), .din(ar_in),
    .dout(ar_head), .empty(ar_empty), .full(ar_full), .count(ar_count)
  );

  // ---------------- burst FSM and address generator ----------------
  state_t                  state, state_nx;
  logic [ADDRESS_BITS-1:0] addr;
  logic [LEN_BITS-1:0]     left, mask;
  logic [1:0]              burst;
  logic [ID_BITS-1:0]      id;
  logic                    cur_oor, issue, last_beat, credit_ok;

  // WRAP mask equals arlen, so arlen must be 2^n-1 for a legal wrap.
  function automatic logic [ADDRESS_BITS-1:0] next_addr(
    input logic [ADDRESS_BITS-1:0] a, input logic [1:0] b, input logic [LEN_BITS-1:0] m);
    logic [ADDRESS_BITS-1:0] mw;
    mw = ADDRESS_BITS'(m);
    case (b)
      BURST_INCR: return a + 1'b1;
      BURST_WRAP: return (a & ~mw) | ((a + 1'b1) & mw);
      default:    return a;
    endcase
  endfunction

  always_comb begin
    issue     = (state == ST_BURST) && (dev_ready || cur_oor) && credit_ok;
    last_beat = issue && (left == '0);
    ar_pop    = !ar_empty && ((state == ST_IDLE) || last_beat);
    state_nx  = state;
    if (ar_pop)         state_nx = ST_BURST;
    else if (last_beat) state_nx = ST_IDLE;
  end

  always_ff @(posedge aclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      addr    <= '0;
      left    <= '0;
      mask    <= '0;
      burst   <= BURST_FIXED;
      id      <= '0;
      cur_oor <= 1'b0;
    end else if (ar_pop) begin
      addr    <= ar_head.addr;
      left    <= ar_head.len;
      mask    <= ar_head.len;
      burst   <= ar_head.burst;
      id      <= ar_head.id;
      cur_oor <= ar_head.oor;
    end else if (issue) begin
      addr <= next_addr(addr, burst, mask);
      left <= left - 1'b1;
    end
  end

  assign start_burst = ar_pop;
  assign pre_araddr  = ar_head.addr;
  assign bram_rclk   = aclk;
  assign bram_ren    = issue && !cur_oor;
  assign bram_raddr  = bram_ren ? addr : '1;

  always_ff @(posedge aclk) begin
    if (rst) bram_regen <= 1'b0;
    else     bram_regen <= bram_ren;
  end

  // ---------------- tag pipe ----------------
  logic [STAGES:0] vld_pipe;
  tag_t            tag_pipe [STAGES+1];
  tag_t            issue_tag;

  assign issue_tag = '{id: id, last: (left == '0), resp: cur_oor ? RESP_SLVERR : RESP_OKAY};

  always_ff @(posedge aclk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i <= STAGES; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // ---------------- output FIFO with bypass ----------------
  beat_t arr_beat, out_head, r_beat;
  logic  arrive, out_empty, out_full, out_push, out_pop;
  logic [clog2(OUT_DEPTH+1)-1:0] out_count;

  assign arrive        = vld_pipe[STAGES];
  assign arr_beat.tag  = tag_pipe[STAGES];
  assign arr_beat.data = (tag_pipe[STAGES].resp == RESP_SLVERR) ? '0 : bram_rdata;

  // Beats still in the tag pipe are counted as occupied slots, so a beat
  // is issued only when its eventual FIFO slot is guaranteed.
  always_comb begin
    credit_ok = (int'(out_count) + $countones(vld_pipe)) < OUT_DEPTH;
  end

  // An arriving beat goes straight to the R channel when the FIFO is empty
  // and the master is ready; otherwise it is parked in the FIFO.
  assign out_push = arrive && !(out_empty && axi.rready);
  assign out_pop  = axi.rready && !out_empty;
  assign r_beat   = out_empty ? arr_beat : out_head;

  fifo_same_clock #(.WIDTH($bits(beat_t)), .DEPTH(OUT_DEPTH)) u_out_q (
    .clk(aclk), .rst(rst), .we(out_push), .re(out_pop), .din(arr_beat),
    .dout(out_head), .empty(out_empty), .full(out_full), .count(out_count)
  );

  assign axi.rvalid = arrive || !out_empty;
  assign axi.rdata  = r_beat.data;
  assign axi.rid    = r_beat.tag.id;
  assign axi.rlast  = r_beat.tag.last;
  assign axi.rresp  = r_beat.tag.resp;

  logic unused_bits;
  assign unused_bits = ^{axi.arsize, axi.araddr[BL-1:0], axi.araddr[31:ADDRESS_BITS+BL],
                         ar_count, out_full};

endmodule

// File: tb/tb_axibram_read_gen.sv
// Randomised scoreboard bench for axibram_read_gen with a BRAM model and a
// burst-expansion reference model; honours AXIBRAM_READ_RANGE_CHECK_EN.
`timescale 1ns/1ps
module tb_axibram_read_gen;
  import axibram_pkg::*;

  localparam int AB  = 10;
  localparam int DB  = 32;
  localparam int IDB = 12;
  localparam int LB  = 4;
  localparam int LAT = 1;
  localparam int ARD = 4;
  localparam int BL  = clog2(DB / 8);

  logic          aclk = 1'b0;
  logic          rst  = 1'b1;
  logic          dev_ready;
  logic [AB-1:0] pre_araddr, bram_raddr;
  logic          start_burst, bram_rclk, bram_ren, bram_regen;
  logic [DB-1:0] bram_rdata;

  always #5 aclk = ~aclk;

  axibram_read_gen_if #(.DATA_BITS(DB), .ID_BITS(IDB), .LEN_BITS(LB)) axi ();

  axibram_read_gen #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .ID_BITS(IDB), .LEN_BITS(LB),
                     .BRAM_LAT(LAT), .AR_DEPTH(ARD)) dut (
    .aclk(aclk), .rst(rst), .axi(axi), .pre_araddr(pre_araddr), .start_burst(start_burst),
    .dev_ready(dev_ready), .bram_rclk(bram_rclk), .bram_raddr(bram_raddr),
    .bram_ren(bram_ren), .bram_regen(bram_regen), .bram_rdata(bram_rdata)
  );

  // BRAM model: memory word is a fixed function of its address
  function automatic logic [DB-1:0] word_at(input logic [AB-1:0] a);
    return DB'(32'h5A00_0000 ^ (32'(a) * 32'h0001_0003));
  endfunction

  logic [DB-1:0] mem_q, reg_q;
  always @(posedge aclk) begin
    if (bram_ren)   mem_q <= word_at(bram_raddr);
    if (bram_regen) reg_q <= mem_q;
  end
  assign bram_rdata = (LAT == 2) ? reg_q : mem_q;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DB-1:0]  data;
    logic [IDB-1:0] id;
    logic           last;
    logic [1:0]     resp;
  } beat_t;

  beat_t         exp_q[$];
  logic [AB-1:0] addr_q[$];
  int            ren_cyc[$];
  int            checks = 0, errors = 0;
  int            first_rv = -1;
  int            rr_mode = 0, dr_mode = 0;   // 0 high, 1 random, 2 low

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: list every beat of the burst from the AXI burst rules
  task automatic model_push(input logic [31:0] a, input logic [IDB-1:0] id,
                            input logic [LB-1:0] len, input logic [1:0] bt);
    int n, w0, base, w;
    bit oor;
    beat_t e;
    n    = int'(len) + 1;
    w0   = int'(a[AB+BL-1:BL]);
    base = (w0 / n) * n;
    oor  = 1'b0;
`ifdef AXIBRAM_READ_RANGE_CHECK_EN
    oor  = (a >> (AB + BL)) != 0;
`endif
    for (int b = 0; b < n; b++) begin
      case (bt)
        2'b01:   w = (w0 + b) % (1 << AB);
        2'b10:   w = base + (w0 - base + b) % n;
        default: w = w0;
      endcase
      if (!oor) addr_q.push_back(AB'(w));
      e.data = oor ? '0 : word_at(AB'(w));
      e.id   = id;
      e.last = (b == n - 1);
      e.resp = oor ? 2'b10 : 2'b00;
      exp_q.push_back(e);
    end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [IDB-1:0] id,
                         input logic [LB-1:0] len, input logic [1:0] bt);
    int t;
    t = 0;
    axi.araddr = a; axi.arid = id; axi.arlen = len; axi.arburst = bt;
    axi.arsize = 3'd2; axi.arvalid = 1'b1;
    @(negedge aclk);
    while (!axi.arready && t < 500) begin @(negedge aclk); t++; end
    if (!axi.arready) begin
      checks++; errors++;
      $display("FAIL ar_handshake: arready stuck low for id %h", id);
    end else model_push(a, id, len, bt);
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 3000) begin
      @(posedge aclk); t++;
    end
    check("drain_outstanding", exp_q.size() + addr_q.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // Drives rready / dev_ready just after each rising edge
  initial begin
    axi.rready = 1'b1;
    dev_ready  = 1'b1;
    forever begin
      @(posedge aclk); #1;
      axi.rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom % 2) : 1'b0;
      dev_ready  = (dr_mode == 0) ? 1'b1 : (dr_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Monitor: BRAM addresses, R beats, and rvalid/payload stability
  beat_t cur, held;
  bit    hold_pend = 1'b0;
  initial forever begin
    @(negedge aclk);
    if (rst) hold_pend = 1'b0;
    else begin
      if (bram_ren) begin
        ren_cyc.push_back(cyc);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bram_raddr: unexpected read of %h", bram_raddr);
        end else check("bram_raddr", bram_raddr, addr_q.pop_front());
      end else check("bram_raddr_idle", bram_raddr, {AB{1'b1}});
      cur = '{axi.rdata, axi.rid, axi.rlast, axi.rresp};
      if (hold_pend) check("rvalid_hold", {axi.rvalid, cur}, {1'b1, held});
      if (axi.rvalid && first_rv < 0) first_rv = cyc;
      if (axi.rvalid && axi.rready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_beat: unexpected beat %h", cur);
        end else check("r_beat", cur, exp_q.pop_front());
      end
      hold_pend = axi.rvalid && !axi.rready;
      held      = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, n;
    logic [31:0] a;
    logic [1:0]  bt;
    logic [LB-1:0] len;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0;
    axi.arlen = '0; axi.arburst = '0; axi.arsize = '0;
    rst = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rlast", axi.rlast, 0);
    check("rst_rresp", axi.rresp, 0);
    check("rst_rid", axi.rid, 0);
    check("rst_bram_ren", bram_ren, 0);
    check("rst_bram_regen", bram_regen, 0);
    check("rst_start_burst", start_burst, 0);
    check("rst_arready", axi.arready, 1);
    rst = 1'b0;
    @(posedge aclk); #1;

    // INCR from word 0x10: latency and 4 beats
    t0 = cyc; first_rv = -1; ren_cyc.delete();
    ar_send(32'h10 << BL, 12'h001, 4'd3, BURST_INCR);
    drain();
    check("first_rvalid_latency", first_rv - t0, LAT + 2);
    check("incr_ren_count", ren_cyc.size(), 4);

    // WRAP and FIXED address sequences
    ar_send(32'h06 << BL, 12'h002, 4'd3, BURST_WRAP);
    ar_send(32'h20 << BL, 12'h003, 4'd2, BURST_FIXED);
    drain();

    // Random rready, long INCR crossing the top of the address space
    rr_mode = 1;
    ar_send(32'h3F8 << BL, 12'h004, 4'd15, BURST_INCR);
    drain();
    rr_mode = 0;
    repeat (2) @(posedge aclk);
    #1;

    // Two queued bursts issue back to back
    ren_cyc.delete();
    ar_send(32'h40 << BL, 12'h005, 4'd1, BURST_INCR);
    ar_send(32'h80 << BL, 12'h00A, 4'd0, BURST_INCR);
    drain();
    check("b2b_ren_count", ren_cyc.size(), 3);
    if (ren_cyc.size() == 3) check("b2b_no_bubble", ren_cyc[2] - ren_cyc[0], 2);

    // dev_ready stall mid-burst while the AR queue fills up
    ar_send(32'h100 << BL, 12'h011, 4'd7, BURST_INCR);
    repeat (2) @(posedge aclk);
    #1;
    dr_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    for (int k = 0; k < ARD; k++) ar_send((32'h200 + 32'(k) * 4) << BL, IDB'(12'h20 + k), 4'd1, BURST_INCR);
    @(negedge aclk);
    check("queue_full_arready", axi.arready, 0);
    repeat (5) @(posedge aclk);
    #1;
    dr_mode = 0;
    drain();

    // Reset in the middle of a stalled burst
    rr_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    ar_send(32'h300 << BL, 12'h033, 4'd15, BURST_INCR);
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    check("pre_rst_rvalid", axi.rvalid, 1);
    @(posedge aclk); #1;
    rst = 1'b1;
    exp_q.delete(); addr_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_rvalid", axi.rvalid, 0);
    @(posedge aclk); #1;
    rst = 1'b0;
    rr_mode = 0;
    @(posedge aclk); #1;
    ar_send(32'h0C << BL, 12'h044, 4'd1, BURST_INCR);
    drain();

`ifdef AXIBRAM_READ_RANGE_CHECK_EN
    ar_send(32'h0001_0000, 12'h055, 4'd1, BURST_INCR);
    drain();
`endif

    // Randomised traffic against the reference model
    rr_mode = 1; dr_mode = 1;
    for (int k = 0; k < 40; k++) begin
      bt  = 2'($urandom_range(0, 3));
      len = (bt == BURST_WRAP) ? LB'((1 << $urandom_range(1, LB)) - 1) : LB'($urandom);
      a   = ($urandom % 4 == 0) ? $urandom : ($urandom & ((32'd1 << (AB + BL)) - 1));
      ar_send(a, IDB'($urandom), len, bt);
      n = $urandom_range(0, 3);
      if (n > 0) begin
        repeat (n) @(posedge aclk);
        #1;
      end
    end
    drain();
    rr_mode = 0; dr_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
